// File: rtl/i2c_slave_fsm_block.sv
// I2C target (slave) endpoint: oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address, receives write bytes into the RX FIFO and serves read bytes from
// the TX FIFO, driving the open-drain lines through active-high pull-low enables.
// Optional build macro: I2C_SLAVE_CLK_STRETCH_EN (SCL stretching on TX empty / RX full
// instead of 8'hFF substitution and full-FIFO NACK).
module i2c_slave_fsm_block #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_bit_i,
    input  logic [6:0] own_addr_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_fifo_full_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_fifo_empty_i,
    output logic       tx_rd_o,
    output logic       busy_o,
    output logic       rw_o,
    output logic       stop_det_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [7:0]             shift_reg;
    logic [7:0]             tx_shift;
    logic [2:0]             bit_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   sda_next;
    logic                   ninth_seen;
    logic                   ack_ok;
    logic                   addr_matched;

    // Synchronised levels and edge events (one delay flop behind the synchroniser)
    logic scl_s, sda_s, scl_rise, scl_fall, scl_edge, start_det, stop_det;
    logic [7:0] shift_byte;
    logic tx_load;
    logic stretching;

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign scl_edge   = scl_s ^ scl_d;
    // An SCL edge in the same cycle masks START/STOP.
    assign start_det  = ~scl_edge & scl_s & sda_d & ~sda_s;
    assign stop_det   = ~scl_edge & scl_s & ~sda_d & sda_s;
    assign shift_byte = {shift_reg[6:0], sda_s};

    // A byte is fetched from the TX FIFO at the end of every ACK slot that leads into TX_DATA.
    assign tx_load = scl_fall & ninth_seen &
                     (((state == ADDR_ACK) & rw_o) | (state == TX_ACK));

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic scl_oe_q;
    logic tx_wait;
    logic rx_stall;
    assign scl_oe_o   = scl_oe_q;
    assign stretching = tx_wait | rx_stall;
`else
    assign scl_oe_o   = 1'b0;
    assign stretching = 1'b0;
`endif

    // Pin synchronisers plus the edge-detect delay flops; idle bus level is high
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, so the chain really is SYNC_STAGES flops deep.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Protocol FSM with registered outputs and the SDA hold-time timer
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            state        <= IDLE;
            shift_reg    <= '0;
            tx_shift     <= '0;
            bit_cnt      <= '0;
            hold_cnt     <= '0;
            sda_next     <= 1'b0;
            ninth_seen   <= 1'b0;
            ack_ok       <= 1'b0;
            addr_matched <= 1'b0;
            sda_oe_o     <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            tx_rd_o      <= 1'b0;
            busy_o       <= 1'b0;
            rw_o         <= 1'b0;
            stop_det_o   <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_q     <= 1'b0;
            tx_wait      <= 1'b0;
            rx_stall     <= 1'b0;
`endif
        end else begin
            rx_valid_o <= 1'b0;
            tx_rd_o    <= 1'b0;
            stop_det_o <= 1'b0;
            if (!enable_bit_i || start_det || stop_det) begin
                sda_oe_o   <= 1'b0;
                hold_cnt   <= '0;
                ninth_seen <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_oe_q   <= 1'b0;
                tx_wait    <= 1'b0;
                rx_stall   <= 1'b0;
`endif
                if (!enable_bit_i) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end else if (start_det) begin
                    state   <= ADDR;
                    bit_cnt <= '0;
                    busy_o  <= 1'b1;
                end else begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    stop_det_o   <= addr_matched;
                    addr_matched <= 1'b0;
                end
            end else begin
                // Apply the queued SDA level HOLD_CYCLES after the SCL fall that queued it.
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HW'(1);
                    if (hold_cnt == HW'(1)) begin
                        sda_oe_o <= sda_next;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        scl_oe_q <= 1'b0;
`endif
                    end
                end
                // NOTE: later non-blocking assignments in this block override this default,
                // so the states below only mention SDA when they want it pulled low.
                if (scl_fall && !stretching) begin
                    sda_next <= 1'b0;
                    hold_cnt <= HW'(HOLD_CYCLES);
                end

                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= shift_byte;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_byte[7:1] == own_addr_i) begin
                                    state        <= ADDR_ACK;
                                    rw_o         <= shift_byte[0];
                                    addr_matched <= 1'b1;
                                    ninth_seen   <= 1'b0;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise) begin
                            ninth_seen <= 1'b1;
                        end else if (scl_fall) begin
                            if (!ninth_seen) begin
                                sda_next <= 1'b1;
                            end else begin
                                ninth_seen <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= rw_o ? TX_DATA : RX_DATA;
                            end
                        end
                    end
                    RX_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        if (rx_stall) begin
                            if (!rx_fifo_full_i) begin
                                rx_data_o  <= shift_reg;
                                rx_valid_o <= 1'b1;
                                rx_stall   <= 1'b0;
                                ack_ok     <= 1'b1;
                                ninth_seen <= 1'b0;
                                state      <= RX_ACK;
                                sda_next   <= 1'b1;
                                hold_cnt   <= HW'(HOLD_CYCLES);
                            end
                        end else
`endif
                        if (scl_rise) begin
                            shift_reg <= shift_byte;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                                if (rx_fifo_full_i) begin
                                    rx_stall <= 1'b1;
                                    scl_oe_q <= 1'b1;
                                    hold_cnt <= '0;
                                end else begin
                                    rx_data_o  <= shift_byte;
                                    rx_valid_o <= 1'b1;
                                    ack_ok     <= 1'b1;
                                    ninth_seen <= 1'b0;
                                    state      <= RX_ACK;
                                end
`else
                                rx_data_o  <= shift_byte;
                                rx_valid_o <= ~rx_fifo_full_i;
                                ack_ok     <= ~rx_fifo_full_i;
                                ninth_seen <= 1'b0;
                                state      <= RX_ACK;
`endif
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_rise) begin
                            ninth_seen <= 1'b1;
                        end else if (scl_fall) begin
                            if (!ninth_seen) begin
                                sda_next <= ack_ok;
                            end else begin
                                ninth_seen <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= ack_ok ? RX_DATA : WAIT_STOP;
                            end
                        end
                    end
                    TX_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        if (tx_wait) begin
                            if (!tx_fifo_empty_i) begin
                                tx_rd_o  <= 1'b1;
                                tx_shift <= tx_data_i;
                                sda_next <= ~tx_data_i[7];
                                hold_cnt <= HW'(HOLD_CYCLES);
                                tx_wait  <= 1'b0;
                            end
                        end else
`endif
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                ninth_seen <= 1'b0;
                                state      <= TX_ACK;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sda_next <= ~tx_shift[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) ninth_seen <= 1'b1;
                            else        state      <= WAIT_STOP;
                        end else if (scl_fall && ninth_seen) begin
                            ninth_seen <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= TX_DATA;
                        end
                    end
                    default: ;
                endcase

                // Fetch the next TX byte and queue its MSB on the bus.
                if (tx_load) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    if (tx_fifo_empty_i) begin
                        tx_wait  <= 1'b1;
                        scl_oe_q <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        tx_rd_o  <= 1'b1;
                        tx_shift <= tx_data_i;
                        sda_next <= ~tx_data_i[7];
                    end
`else
                    tx_rd_o  <= ~tx_fifo_empty_i;
                    tx_shift <= tx_fifo_empty_i ? 8'hFF : tx_data_i;
                    sda_next <= tx_fifo_empty_i ? 1'b0 : ~tx_data_i[7];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_fsm_block.sv
// Directed bench for i2c_slave_fsm_block: a bit-banged I2C master drives the pins
// through a wired-AND bus model; FIFOs and strobes are tracked by a monitor.
module tb_i2c_slave_fsm_block;

    localparam int Q = 16;  // core cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       m_scl;
    logic       m_sda;
    logic       rx_full;
    logic       sda_oe, scl_oe, rx_valid, tx_rd, busy, rw, stop_det;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       scl_line, sda_line;

    logic [7:0] tx_fifo [0:15];
    logic [7:0] rx_log  [0:15];
    int tx_count    = 0;
    int tx_head     = 0;
    int rx_cnt      = 0;
    int stop_cnt    = 0;
    int sda_low_cnt = 0;
    int tests       = 0;
    int fails       = 0;

    always #5 clk = ~clk;

    assign scl_line = m_scl & ~scl_oe;
    assign sda_line = m_sda & ~sda_oe;
    assign tx_data  = tx_fifo[tx_head % 16];
    assign tx_empty = (tx_head >= tx_count);

    i2c_slave_fsm_block dut (
        .i2c_core_clock_i (clk),
        .reset_bit_i      (rst_n),
        .enable_bit_i     (enable),
        .own_addr_i       (7'h42),
        .scl_i            (scl_line),
        .sda_i            (sda_line),
        .sda_oe_o         (sda_oe),
        .scl_oe_o         (scl_oe),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_fifo_full_i   (rx_full),
        .tx_data_i        (tx_data),
        .tx_fifo_empty_i  (tx_empty),
        .tx_rd_o          (tx_rd),
        .busy_o           (busy),
        .rw_o             (rw),
        .stop_det_o       (stop_det)
    );

    // Strobe monitor: records RX bytes, TX pops, STOP pulses and SDA pull-low cycles
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 16] = rx_data;
            rx_cnt++;
        end
        if (tx_rd)    tx_head++;
        if (stop_det) stop_cnt++;
        if (sda_oe)   sda_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_fifo[tx_count % 16] = b;
        tx_count++;
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        seen = sda_line;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int base_rx, base_tx, base_stop, base_sda;

        for (int i = 0; i < 16; i++) tx_fifo[i] = 8'h00;
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        rx_full = 1'b0;
        tick(3);
        check("reset_outputs", {25'd0, sda_oe, scl_oe, busy, rw, rx_valid, tx_rd, stop_det}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Write 0x42: three bytes all ACKed, two stored, one STOP pulse
        base_rx   = rx_cnt;
        base_stop = stop_cnt;
        start_cond();
        check("wr_busy_after_start", {31'd0, busy}, 32'd1);
        write_byte(8'h84, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd1);
        check("wr_rw", {31'd0, rw}, 32'd0);
        write_byte(8'hA5, ack);
        check("wr_data1_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h3C, ack);
        check("wr_data2_ack", {31'd0, ack}, 32'd1);
        stop_cond();
        tick(4);
        check("wr_rx_count", rx_cnt - base_rx, 32'd2);
        check("wr_rx_byte0", {24'd0, rx_log[base_rx % 16]}, 32'hA5);
        check("wr_rx_byte1", {24'd0, rx_log[(base_rx + 1) % 16]}, 32'h3C);
        check("wr_stop_pulses", stop_cnt - base_stop, 32'd1);
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

        // Foreign address 0x43: SDA never pulled, no strobes
        base_rx   = rx_cnt;
        base_tx   = tx_head;
        base_stop = stop_cnt;
        base_sda  = sda_low_cnt;
        start_cond();
        write_byte(8'h86, ack);
        check("nomatch_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h55, ack);
        check("nomatch_busy", {31'd0, busy}, 32'd1);
        stop_cond();
        tick(4);
        check("nomatch_busy_after_stop", {31'd0, busy}, 32'd0);
        check("nomatch_sda_low", sda_low_cnt - base_sda, 32'd0);
        check("nomatch_rx", rx_cnt - base_rx, 32'd0);
        check("nomatch_tx", tx_head - base_tx, 32'd0);
        check("nomatch_stop", stop_cnt - base_stop, 32'd0);

        // Read 0x42: FIFO 5A,C3; master ACKs then NACKs
        push_tx(8'h5A);
        push_tx(8'hC3);
        base_tx = tx_head;
        start_cond();
        write_byte(8'h85, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        check("rd_rw", {31'd0, rw}, 32'd1);
        read_byte(d, 1'b1);
        check("rd_byte0", {24'd0, d}, 32'h5A);
        read_byte(d, 1'b0);
        check("rd_byte1", {24'd0, d}, 32'hC3);
        check("rd_sda_released", {31'd0, sda_oe}, 32'd0);
        check("rd_pops", tx_head - base_tx, 32'd2);
        stop_cond();
        tick(4);

        // Receive FIFO full on the second data byte: NACK, then ignore until STOP
        base_rx = rx_cnt;
        start_cond();
        write_byte(8'h84, ack);
        write_byte(8'h11, ack);
        check("full_first_ack", {31'd0, ack}, 32'd1);
        rx_full = 1'b1;
        write_byte(8'h22, ack);
        check("full_second_nack", {31'd0, ack}, 32'd0);
        check("full_sda_released", {31'd0, sda_oe}, 32'd0);
        check("full_busy", {31'd0, busy}, 32'd1);
        rx_full = 1'b0;
        write_byte(8'h33, ack);
        check("full_wait_stop_nack", {31'd0, ack}, 32'd0);
        check("full_rx_count", rx_cnt - base_rx, 32'd1);
        check("full_rx_byte", {24'd0, rx_log[base_rx % 16]}, 32'h11);
        stop_cond();
        tick(4);

        // Write then repeated START into a read
        push_tx(8'h96);
        start_cond();
        write_byte(8'h84, ack);
        check("rs_rw_write", {31'd0, rw}, 32'd0);
        write_byte(8'h11, ack);
        start_cond();
        write_byte(8'h85, ack);
        check("rs_read_ack", {31'd0, ack}, 32'd1);
        check("rs_rw_read", {31'd0, rw}, 32'd1);
        read_byte(d, 1'b0);
        check("rs_read_byte", {24'd0, d}, 32'h96);
        stop_cond();
        tick(4);

        // Reset in the middle of a read byte of all zeros releases SDA at once
        push_tx(8'h00);
        start_cond();
        write_byte(8'h85, ack);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
        check("midrst_sda_driven", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_sda_released", {31'd0, sda_oe}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
